// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared constants and FSM encoding for the PHY receive sync controller
package phy_rx_pkg;

    localparam logic [7:0] COM_BYTE_DEF   = 8'hBC;
    localparam int         SYNC_COUNT_DEF = 4;
    localparam int         LOS_CYCLES_DEF = 8;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_ACTIVE = 1'b1
    } sync_state_e;

endpackage

// File: rtl/phy_rx_word_pack.sv
// rtl/phy_rx_word_pack.sv - packs accepted data bytes MSB-first into 32-bit words
module phy_rx_word_pack (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        flush,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        err_partial
);

    logic [1:0]  idx_q,   idx_d;
    logic [23:0] word_q,  word_d;
    logic [31:0] data_q,  data_d;
    logic        valid_q, valid_d;
    logic        err_q,   err_d;

    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (flush) begin
            // A flush at index 0 has nothing to throw away, so it is silent.
            err_d  = (idx_q != 2'd0);
            idx_d  = 2'd0;
            word_d = 24'h0;
        end else if (byte_valid) begin
            if (idx_q == 2'd3) begin
                data_d  = {word_q, byte_in};
                valid_d = 1'b1;
                idx_d   = 2'd0;
                word_d  = 24'h0;
            end else begin
                word_d = {word_q[15:0], byte_in};
                idx_d  = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            idx_q   <= 2'd0;
            word_q  <= 24'h0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign err_partial = err_q;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// rtl/phy_rx_sync_ctrl.sv - comma-based lane sync FSM with loss-of-signal detection
module phy_rx_sync_ctrl
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM_BYTE   = COM_BYTE_DEF,
    parameter int         SYNC_COUNT = SYNC_COUNT_DEF,
    parameter int         LOS_CYCLES = LOS_CYCLES_DEF
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [7:0]  data_in,
    input  logic        data_in_valid,
    output logic        active,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        err_partial
);

    localparam int CW = $clog2(SYNC_COUNT) + 1;
    localparam int LW = $clog2(LOS_CYCLES) + 1;

    sync_state_e   state_q,   state_d;
    logic [CW-1:0] com_cnt_q, com_cnt_d;
    logic [LW-1:0] los_cnt_q, los_cnt_d;
    logic          pack_en;
    logic          flush;
    logic          is_com;

    assign is_com = (data_in == COM_BYTE);

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        los_cnt_d = los_cnt_q;
        pack_en   = 1'b0;
        flush     = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                los_cnt_d = '0;
                if (data_in_valid) begin
                    if (!is_com) begin
                        com_cnt_d = '0;
                    end else if (com_cnt_q == CW'(SYNC_COUNT - 1)) begin
                        state_d   = ST_ACTIVE;
                        com_cnt_d = '0;
                    end else begin
                        com_cnt_d = com_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                com_cnt_d = '0;
                if (data_in_valid) begin
                    los_cnt_d = '0;
                    flush     = is_com;
                    pack_en   = !is_com;
                end else if (los_cnt_q == LW'(LOS_CYCLES - 1)) begin
                    // Loss of sync drops any half-built word on the same edge.
                    state_d   = ST_SEARCH;
                    los_cnt_d = '0;
                    flush     = 1'b1;
                end else begin
                    los_cnt_d = los_cnt_q + LW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_SEARCH;
            com_cnt_q <= '0;
            los_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            los_cnt_q <= los_cnt_d;
        end
    end

    assign active = (state_q == ST_ACTIVE);

    phy_rx_word_pack u_word_pack (
        .clk_4f      (clk_4f),
        .reset_L     (reset_L),
        .byte_valid  (pack_en),
        .byte_in     (data_in),
        .flush       (flush),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .err_partial (err_partial)
    );

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// tb/tb_phy_rx_sync_ctrl.sv - randomized self-checking bench for phy_rx_sync_ctrl
module tb_phy_rx_sync_ctrl;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         SYNC_N = 4;
    localparam int         LOS_N  = 8;

    logic        clk_4f = 1'b0;
    logic        reset_L;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        active;
    logic [31:0] data_out;
    logic        valid_out;
    logic        err_partial;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: lane synced flag, comma run length, idle run length, pending bytes.
    bit          m_synced;
    int          m_run;
    int          m_idle;
    logic [7:0]  m_bytes[$];
    logic [31:0] e_data;
    logic        e_valid;
    logic        e_err;
    int          n_words;
    int          n_errs;

    always #5 clk_4f = ~clk_4f;

    phy_rx_sync_ctrl #(
        .COM_BYTE   (COM),
        .SYNC_COUNT (SYNC_N),
        .LOS_CYCLES (LOS_N)
    ) dut (
        .clk_4f        (clk_4f),
        .reset_L       (reset_L),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .active        (active),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .err_partial   (err_partial)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_synced = 0;
        m_run    = 0;
        m_idle   = 0;
        m_bytes.delete();
        e_data   = 32'h0;
        e_valid  = 0;
        e_err    = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] b);
        e_valid = 0;
        e_err   = 0;
        if (!m_synced) begin
            if (v) begin
                if (b == COM) begin
                    m_run++;
                    if (m_run == SYNC_N) begin
                        m_synced = 1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end else if (v) begin
            m_idle = 0;
            if (b == COM) begin
                e_err = (m_bytes.size() != 0);
                m_bytes.delete();
            end else begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    e_data  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    e_valid = 1;
                    m_bytes.delete();
                end
            end
        end else begin
            m_idle++;
            if (m_idle == LOS_N) begin
                m_synced = 0;
                m_idle   = 0;
                e_err    = (m_bytes.size() != 0);
                m_bytes.delete();
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".active"}, 32'(active), 32'(m_synced));
        check_val({tag, ".valid"}, 32'(valid_out), 32'(e_valid));
        check_val({tag, ".err"}, 32'(err_partial), 32'(e_err));
        check_val({tag, ".data"}, data_out, e_data);
        if (valid_out && err_partial) check_val({tag, ".exclusive"}, 32'd1, 32'd0);
        if (e_valid) n_words++;
        if (e_err) n_errs++;
    endtask

    task automatic cyc(input string tag, input bit v, input logic [7:0] b);
        data_in_valid = v;
        data_in       = b;
        @(posedge clk_4f);
        model_step(v, b);
        #1;
        check_outputs(tag);
    endtask

    task automatic sync_up(input string tag);
        for (int i = 0; i < SYNC_N; i++) cyc(tag, 1'b1, COM);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge clk_4f);
        #1;
        check_outputs("reset_hold");
        reset_L = 1'b1;
    endtask

    initial begin
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        n_words       = 0;
        n_errs        = 0;
        #2;
        do_reset();

        // 3 commas broken by a data byte, then a full comma run
        for (int i = 0; i < 3; i++) cyc("pre3", 1'b1, COM);
        cyc("break", 1'b1, 8'h55);
        check_val("no_sync_after_3", 32'(active), 32'd0);
        sync_up("sync");
        check_val("sync_after_8", 32'(active), 32'd1);

        cyc("w1", 1'b1, 8'h12);
        cyc("w1", 1'b1, 8'h34);
        cyc("w1", 1'b1, 8'h56);
        cyc("w1", 1'b1, 8'h78);
        check_val("word_12345678", data_out, 32'h12345678);
        check_val("word_valid", 32'(valid_out), 32'd1);

        cyc("p1", 1'b1, 8'hAA);
        cyc("p1", 1'b1, 8'hBB);
        cyc("p1", 1'b1, COM);
        check_val("partial_err", 32'(err_partial), 32'd1);
        cyc("w2", 1'b1, 8'h01);
        cyc("w2", 1'b1, 8'h02);
        cyc("w2", 1'b1, 8'h03);
        cyc("w2", 1'b1, 8'h04);
        check_val("word_01020304", data_out, 32'h01020304);

        // idle commas at index 0 and 7-cycle gaps keep sync
        for (int w = 0; w < 3; w++) begin
            cyc("idle", 1'b1, COM);
            for (int k = 0; k < 4; k++) begin
                cyc("gap_byte", 1'b1, 8'(8'h20 + 8'(w * 4 + k)));
                for (int g = 0; g < LOS_N - 1; g++) cyc("gap", 1'b0, 8'h00);
            end
        end
        check_val("gap_keeps_sync", 32'(active), 32'd1);

        cyc("los", 1'b1, 8'hC1);
        cyc("los", 1'b1, 8'hC2);
        for (int g = 0; g < LOS_N; g++) cyc("los_gap", 1'b0, 8'h00);
        check_val("los_err", 32'(err_partial), 32'd1);
        cyc("los_after", 1'b0, 8'h00);
        check_val("los_inactive", 32'(active), 32'd0);
        for (int k = 0; k < 6; k++) cyc("unsynced", 1'b1, 8'(8'h40 + 8'(k)));
        sync_up("resync");
        check_val("resynced", 32'(active), 32'd1);

        cyc("mid", 1'b1, 8'hD1);
        cyc("mid", 1'b1, 8'hD2);
        @(negedge clk_4f);
        do_reset();
        check_val("rst_inactive", 32'(active), 32'd0);
        for (int k = 0; k < 4; k++) cyc("post_rst", 1'b1, 8'(8'h60 + 8'(k)));
        sync_up("resync2");

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                int len = $urandom_range(LOS_N - 2, LOS_N + 3);
                for (int g = 0; g < len; g++) cyc("rnd_gap", 1'b0, 8'($urandom));
            end else begin
                bit v = ($urandom_range(0, 3) != 0);
                logic [7:0] b;
                b = ($urandom_range(0, 99) < 30) ? COM : 8'($urandom);
                cyc("rnd", v, b);
            end
        end
        check_val("saw_words", 32'(n_words > 10), 32'd1);
        check_val("saw_errs", 32'(n_errs > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/phy_rx_sync_ctrl.md
PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 SHALL have parameter COM_BYTE, default 8'hBC, comma/idle symbol.
REQ-002 SHALL have parameter SYNC_COUNT, default 4, consecutive commas required to declare sync.
REQ-003 SHALL have parameter LOS_CYCLES, default 8, consecutive cycles without data_in_valid that declare loss of sync.
REQ-004 clk_4f  input  1  sole clock, byte rate of the serial-to-parallel converter; all logic on rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  8  byte from the serial-to-parallel converter, MSB received first.
REQ-007 data_in_valid  input  1  data_in holds a complete byte this cycle.
REQ-008 active  output  1  lane synchronized; registered.
REQ-009 data_out  output  32  packed data word; registered.
REQ-010 valid_out  output  1  one-cycle pulse, data_out holds a new word.
REQ-011 err_partial  output  1  one-cycle pulse, a partially packed word was discarded.

Function
REQ-012 SHALL implement a two-state FSM: SEARCH and ACTIVE; active SHALL be high exactly when the registered state is ACTIVE.
REQ-013 In SEARCH, each accepted byte (data_in_valid=1) equal to COM_BYTE SHALL increment com_cnt; an accepted non-COM byte SHALL clear com_cnt; cycles with data_in_valid=0 SHALL hold com_cnt.
REQ-014 SEARCH->ACTIVE SHALL occur on the edge that accepts the SYNC_COUNT-th consecutive COM; active rises one cycle after that byte is presented; com_cnt clears.
REQ-015 In SEARCH, no byte SHALL be packed and valid_out SHALL stay 0.
REQ-016 In ACTIVE, accepted COM bytes SHALL be treated as idle and not packed.
REQ-017 In ACTIVE, accepted non-COM bytes SHALL be packed MSB-first: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-018 On the edge accepting the 4th data byte, data_out SHALL load the full word and valid_out SHALL be 1 for the following cycle only; byte index wraps 3->0.
REQ-019 data_out SHALL hold its last value between valid_out pulses.
REQ-020 A COM accepted in ACTIVE while byte index is 1..3 SHALL discard the partial word, reset index to 0 and pulse err_partial; index 0 COM SHALL raise no error.
REQ-021 In ACTIVE, a counter SHALL count consecutive data_in_valid=0 cycles, clearing on any accepted byte; reaching LOS_CYCLES SHALL return FSM to SEARCH on that edge, active falling the next cycle.
REQ-022 On loss of sync with index 1..3, the partial word SHALL be discarded and err_partial pulsed once; index and com_cnt SHALL be 0 on entering SEARCH.
REQ-023 The first byte accepted after a SEARCH->ACTIVE transition SHALL be processed under ACTIVE rules (no dead cycle).
REQ-024 valid_out and err_partial SHALL never be high in the same cycle.

Reset
REQ-025 While reset_L=0: state=SEARCH, active=0, data_out=32'h0, valid_out=0, err_partial=0, com_cnt=0, byte index=0, loss counter=0, partial word register=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word without an err_partial pulse; after release, sync SHALL restart from SEARCH.

Structure
REQ-027 Package phy_rx_pkg SHALL hold COM_BYTE default, FSM state encoding, and default SYNC_COUNT/LOS_CYCLES constants.
REQ-028 Byte packing (index, shift register, valid_out, err_partial) SHALL be a sub-module phy_rx_word_pack; FSM and counters in phy_rx_sync_ctrl.
REQ-029 Counter widths SHALL be $clog2 of their parameter plus one; no counter SHALL wrap.

Verification
REQ-030 Reset, then 3 x BC, 1 x 8'h55, 4 x BC (valid=1 every cycle) -> active rises the cycle after the 8th byte, not after the 3rd.
REQ-031 After sync, bytes 8'h12,8'h34,8'h56,8'h78 -> one valid_out pulse, data_out=32'h12345678, active stays 1.
REQ-032 After sync, 8'hAA,8'hBB, BC, 8'h01,8'h02,8'h03,8'h04 -> err_partial pulse on the BC, then data_out=32'h01020304 with valid_out.
REQ-033 After sync, data bytes interleaved with BC idles at index 0 and valid=0 gaps of 7 cycles -> correct words, no err_partial, active stays 1.
REQ-034 After sync, 2 data bytes then valid=0 for 8 cycles -> err_partial once, active falls, subsequent data bytes produce no valid_out until 4 BC re-sync.
REQ-035 reset_L pulsed low mid-word in ACTIVE -> all outputs 0 immediately, no err_partial, resync required.
